// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the bare MIPS core. It is a Moore FSM except for the FETCH IRWrite/PCWrite terms.
// Optional feature macro: MC_CTRL_BNE_EN (decode opcode 0x05 as bne).
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMMEXEC  = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    state_t     state_q, state_d;
    logic [2:0] aluop_q, aluop_d;
    logic       funct_ok;
    logic [2:0] funct_aluop;
    ctl_t       ctl, ctl_gated;

    // The branch comparison itself lives in the datapath; the flag only passes through here.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        funct_ok    = 1'b1;
        funct_aluop = ALU_ADD;
        case (funct)
            6'h20:   funct_aluop = ALU_ADD;
            6'h22:   funct_aluop = ALU_SUB;
            6'h24:   funct_aluop = ALU_AND;
            6'h25:   funct_aluop = ALU_OR;
            6'h2A:   funct_aluop = ALU_SLT;
            default: funct_ok    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            aluop_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            aluop_q <= aluop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aluop_d = aluop_q;
        ctl     = '0;
        ctl.ext_op = 1'b1;

        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'd2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        state_d = S_EXECUTE;
                        aluop_d = funct_aluop;
                    end
                    OP_BEQ:   state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:   state_d = S_BRANCH;
`endif
                    OP_ADDI, OP_ORI: begin
                        state_d = S_IMMEXEC;
                        aluop_d = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                    end
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.i_or_d   = 1'b1;
                ctl.mem_read = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = aluop_q;
                state_d = funct_ok ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                ctl.alu_op    = aluop_q;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'd1;
`ifdef MC_CTRL_BNE_EN
                ctl.branch_ne     = (opcode == OP_BNE);
`endif
                state_d = S_FETCH;
            end
            S_IMMEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'd2;
                ctl.ext_op    = (opcode != OP_ORI);
                ctl.alu_op    = aluop_q;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                ctl.reg_write = 1'b1;
                ctl.alu_op    = aluop_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'd2;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                ctl.illegal_op = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset blanks every control line combinationally so an aborted access cannot commit.
    assign ctl_gated = rst_n ? ctl : '0;

    assign PCWrite     = ctl_gated.pc_write;
    assign PCWriteCond = ctl_gated.pc_write_cond;
    assign BranchNe    = ctl_gated.branch_ne;
    assign IorD        = ctl_gated.i_or_d;
    assign MemRead     = ctl_gated.mem_read;
    assign MemWrite    = ctl_gated.mem_write;
    assign IRWrite     = ctl_gated.ir_write;
    assign MemtoReg    = ctl_gated.mem_to_reg;
    assign RegDst      = ctl_gated.reg_dst;
    assign RegWrite    = ctl_gated.reg_write;
    assign ALUSrcA     = ctl_gated.alu_src_a;
    assign ALUSrcB     = ctl_gated.alu_src_b;
    assign ExtOp       = ctl_gated.ext_op;
    assign ALUOp       = ctl_gated.alu_op;
    assign PCSource    = ctl_gated.pc_source;
    assign IllegalOp   = ctl_gated.illegal_op;
    assign state       = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the 32-bit bare MIPS core. It walks each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath select and write enable, including the 2-bit ALU operand-B select consumed by the operand-B mux (0 = register B, 1 = constant 1 for the word-addressed PC increment, 2 = extended immediate). It sits between the instruction register and the datapath. It is a Moore FSM, except for the memory-ready qualification described below.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if branch condition true
- BranchNe  out  1  branch condition is !zero (else zero)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  0 = register B, 1 = constant 1, 2 = extended immediate
- ExtOp  out  1  immediate extend: 1 = sign, 0 = zero
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:26], IR[25:0]}
- IllegalOp  out  1  one-cycle pulse for an unsupported opcode or funct
- state  out  4  current state, for debug

## Operation
State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, ILLEGAL 12.

Unlisted outputs are 0 in every state. ExtOp defaults to 1.

- **FETCH:** IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0.
  - IRWrite=PCWrite=mem_ready. These are the only Mealy terms.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- **DECODE:** ALUSrcA=0, ALUSrcB=2, ExtOp=1, ALUOp=add. This precomputes the branch target PC+1+simm. Next state by opcode:
  - 0x23 or 0x2B → MEMADR
  - 0x00 → EXECUTE
  - 0x04 → BRANCH
  - 0x08 or 0x0D → IMMEXEC
  - 0x02 → JUMP
  - anything else → ILLEGAL
- **MEMADR:** ALUSrcA=1, ALUSrcB=2, ExtOp=1, add. Opcode 0x23 → MEMREAD; 0x2B → MEMWRITE.
- **MEMREAD:** IorD=1, MemRead=1. Hold until mem_ready=1, then → MEMWB.
- **MEMWB:** RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
- **MEMWRITE:** IorD=1, MemWrite=1. Hold until mem_ready=1, then → FETCH.
- **EXECUTE:** ALUSrcA=1, ALUSrcB=0. ALUOp from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct → ILLEGAL; a valid funct → ALUWB.
- **ALUWB:** RegWrite=1, RegDst=1, MemtoReg=0. ALUOp is held from EXECUTE in a register. → FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCWriteCond=1, PCSource=1, BranchNe per opcode. → FETCH.
- **IMMEXEC:** ALUSrcA=1, ALUSrcB=2.
  - 0x08: ExtOp=1, add.
  - 0x0D: ExtOp=0, or.
  - → IMMWB.
- **IMMWB:** RegWrite=1, RegDst=0. → FETCH.
- **JUMP:** PCWrite=1, PCSource=2. → FETCH.
- **ILLEGAL:** IllegalOp=1, no architectural writes. → FETCH.

## Timing
- Reset: while rst_n=0, state=FETCH and every output is forced to 0, including MemRead. The first fetch request appears in the first cycle after rst_n rises.
- Reset asserted mid-instruction aborts it immediately. No partial register writes occur after assertion.
- Cycle counts with zero wait states:
  - lw: 5
  - sw, R-type, addi, ori: 4
  - beq, j, illegal: 3
- Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle. Outputs are held stable while waiting.
- mem_ready is ignored in all other states.
- ALUOp is registered on entry to EXECUTE and IMMEXEC, so it is glitch-free in ALUWB and IMMWB.

## Configuration
- MC_CTRL_BNE_EN
  - Defined: opcode 0x05 is decoded in DECODE → BRANCH with BranchNe=1 in BRANCH.
  - Undefined: 0x05 → ILLEGAL, and BranchNe is tied to 0.

## Test plan
- Reset release, mem_ready=1, IR=lw (0x23) → states 0,1,2,3,4,0; MemRead=1 in states 0 and 3; RegWrite=1 and MemtoReg=1 only in state 4.
- FETCH with mem_ready held 0 for 3 cycles → state stays 0, IRWrite=PCWrite=0 for those cycles, then a single 1-cycle pulse when mem_ready=1.
- R-type funct 0x22 → ALUOp=001 in states 6 and 7, RegDst=1 in 7. Funct 0x3F → state 12 with IllegalOp=1 for exactly one cycle, RegWrite never set.
- beq with zero=1 → BRANCH shows PCWriteCond=1, PCSource=1, ALUSrcB=0, BranchNe=0. Opcode 0x05 → BranchNe=1 with MC_CTRL_BNE_EN defined, state 12 without.
- ori 0x0D → IMMEXEC shows ExtOp=0, ALUOp=011, ALUSrcB=2. addi 0x08 → ExtOp=1, ALUOp=000.
- rst_n pulled low during MEMREAD → all outputs 0 asynchronously, state=0; restart fetches from PC.
